// File: rtl/dsp_pwm_pkg.sv
// Shared defaults and helpers for the dithered PWM DAC channels.
// Holds the default widths, the offset-binary mapping and the dither bit-reversal.
package dsp_pwm_pkg;

  localparam int DEF_CNT_BITS    = 8;
  localparam int DEF_DITHER_BITS = 4;
  localparam int DEF_DAT_BITS    = 14;

  // Two's complement to offset binary: most negative sample maps to zero duty.
  function automatic logic [DEF_DAT_BITS-1:0] offset_map(input logic [DEF_DAT_BITS-1:0] dat);
    return {~dat[DEF_DAT_BITS-1], dat[DEF_DAT_BITS-2:0]};
  endfunction

  function automatic logic [DEF_DITHER_BITS-1:0] bitrev(input logic [DEF_DITHER_BITS-1:0] v);
    logic [DEF_DITHER_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < DEF_DITHER_BITS; i++) begin
      r[i] = v[DEF_DITHER_BITS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_pwm_dither.sv
// One PWM DAC channel: coarse duty per period plus a bit-reversed dither
// sequence that spreads the fractional part evenly over 16 periods.
module dsp_pwm_dither
  import dsp_pwm_pkg::*;
#(
  parameter int CNT_BITS    = DEF_CNT_BITS,
  parameter int DITHER_BITS = DEF_DITHER_BITS,
  parameter int DAT_BITS    = DEF_DAT_BITS
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [DAT_BITS-1:0] dat_i,
  input  logic                enable_i,
  output logic                pwm_o,
  output logic                period_strobe_o,
  output logic [DAT_BITS-1:0] sample_o
);

  localparam int LSB_BITS = DAT_BITS - CNT_BITS - DITHER_BITS;
  localparam logic [CNT_BITS-1:0]    CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [DITHER_BITS-1:0] PCNT_ONE = {{(DITHER_BITS-1){1'b0}}, 1'b1};

  logic [CNT_BITS-1:0]    r_cnt;
  logic [DITHER_BITS-1:0] r_pcnt;
  logic [CNT_BITS:0]      r_high_q;
  logic [DAT_BITS-1:0]    r_sample;
  logic                   r_pwm;
  logic                   r_strobe;

  logic [DAT_BITS-1:0]    w_u;
  logic [CNT_BITS-1:0]    w_coarse;
  logic [DITHER_BITS-1:0] w_dither;
  logic [LSB_BITS-1:0]    w_unused_lsbs;
  logic [DITHER_BITS-1:0] w_pcnt_next;
  logic                   w_extra;
  logic [CNT_BITS:0]      w_high_next;
  logic                   w_wrap;
  logic                   w_below;

  assign w_u = offset_map(dat_i);
  assign {w_coarse, w_dither, w_unused_lsbs} = w_u;

  // The extra cycle is decided against the period index about to start.
  assign w_pcnt_next = r_pcnt + PCNT_ONE;
  assign w_extra     = (w_dither > bitrev(w_pcnt_next));
  assign w_high_next = {1'b0, w_coarse} + {{CNT_BITS{1'b0}}, w_extra};

  assign w_wrap  = (r_cnt == {CNT_BITS{1'b1}});
  assign w_below = ({1'b0, r_cnt} < r_high_q);

  // Idle parks the counters at the wrap point so the first enabled cycle loads.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt    <= {CNT_BITS{1'b1}};
      r_pcnt   <= {DITHER_BITS{1'b1}};
      r_high_q <= '0;
      r_sample <= '0;
      r_pwm    <= 1'b0;
      r_strobe <= 1'b0;
    end else if (!enable_i) begin
      r_cnt    <= {CNT_BITS{1'b1}};
      r_pcnt   <= {DITHER_BITS{1'b1}};
      r_pwm    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + CNT_ONE;
      r_pwm    <= w_below;
      r_strobe <= w_wrap;
      if (w_wrap) begin
        r_pcnt   <= w_pcnt_next;
        r_sample <= dat_i;
        r_high_q <= w_high_next;
      end
    end
  end

  assign pwm_o           = r_pwm;
  assign period_strobe_o = r_strobe;
  assign sample_o        = r_sample;

endmodule

// File: tb/tb_dsp_pwm_dither.sv
// Self-checking bench for dsp_pwm_dither: table-driven duty checks over 16 periods,
// hand-written corner sequences and a randomized run against a cycle reference model.
module tb_dsp_pwm_dither;

  logic        clk_i;
  logic        rstn_i;
  logic [13:0] dat_i;
  logic        enable_i;
  logic        pwm_o;
  logic        period_strobe_o;
  logic [13:0] sample_o;

  int nChecks = 0;
  int nErrors = 0;
  int cycle   = 0;

  int mCnt, mPer, mHigh, mSample, mPwm, mStrobe;

  typedef struct {
    logic [13:0] dat;
    int          expFirst;
    int          expTotal;
    int          expMin;
    int          expMax;
  } vec_t;

  vec_t vecs[7];

  dsp_pwm_dither dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .dat_i          (dat_i),
    .enable_i       (enable_i),
    .pwm_o          (pwm_o),
    .period_strobe_o(period_strobe_o),
    .sample_o       (sample_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Spec-level duty: offset-binary coarse field plus one cycle when dither beats bitrev(period).
  function automatic int expectedHigh(input int d, input int p);
    int u, coarse, dith, rev;
    u      = d ^ 'h2000;
    coarse = u / 64;
    dith   = (u / 4) % 16;
    rev    = 0;
    for (int i = 0; i < 4; i++) begin
      if (((p >> i) & 1) == 1) rev += (1 << (3 - i));
    end
    return coarse + ((dith > rev) ? 1 : 0);
  endfunction

  task automatic modelReset();
    mCnt = 255; mPer = 15; mHigh = 0; mSample = 0; mPwm = 0; mStrobe = 0;
  endtask

  task automatic modelClock();
    if (!enable_i) begin
      mCnt = 255; mPer = 15; mPwm = 0; mStrobe = 0;
    end else begin
      mPwm    = (mCnt < mHigh) ? 1 : 0;
      mStrobe = (mCnt == 255) ? 1 : 0;
      if (mCnt == 255) begin
        mPer    = (mPer + 1) % 16;
        mSample = int'(dat_i);
        mHigh   = expectedHigh(int'(dat_i), mPer);
      end
      mCnt = (mCnt + 1) % 256;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycle, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [13:0] d);
    enable_i = en;
    dat_i    = d;
  endtask

  task automatic step();
    @(posedge clk_i);
    if (rstn_i) modelClock();
    @(negedge clk_i);
    cycle++;
    checkOutput("pwm", int'(pwm_o), mPwm);
    checkOutput("strobe", int'(period_strobe_o), mStrobe);
    checkOutput("sample", int'(sample_o), mSample);
  endtask

  task automatic waitStrobe(output int n);
    n = 0;
    while (n < 600) begin
      step();
      n++;
      if (period_strobe_o) return;
    end
    checkOutput("strobe_timeout", 0, 1);
  endtask

  task automatic countPeriod(output int hc);
    hc = 0;
    for (int c = 0; c < 256; c++) begin
      step();
      hc += int'(pwm_o);
    end
    checkOutput("strobe_spacing", int'(period_strobe_o), 1);
  endtask

  initial begin
    int n, hc, total, mn, mx, strobes;

    vecs[0] = '{14'h0000, 128, 2048, 128, 128};
    vecs[1] = '{14'h0020, 129, 2056, 128, 129};
    vecs[2] = '{14'h2000, 0,    0,    0,   0};
    vecs[3] = '{14'h1FFF, 256, 4095, 255, 256};
    vecs[4] = '{14'h1000, 192, 3072, 192, 192};
    vecs[5] = '{14'h0004, 129, 2049, 128, 129};
    vecs[6] = '{14'h3FFF, 128, 2047, 127, 128};

    rstn_i = 1'b0;
    modelReset();
    applyStimulus(1'b0, 14'h0000);
    @(negedge clk_i);
    checkOutput("reset_pwm", int'(pwm_o), 0);
    checkOutput("reset_strobe", int'(period_strobe_o), 0);
    checkOutput("reset_sample", int'(sample_o), 0);
    applyStimulus(1'b1, 14'h1234);
    repeat (2) step();
    #2 rstn_i = 1'b1;
    applyStimulus(1'b0, 14'h0000);
    step();

    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].dat);
      repeat (3) step();
      applyStimulus(1'b1, vecs[i].dat);
      waitStrobe(n);
      checkOutput("first_strobe_latency", n, 1);
      total = 0; mn = 1000; mx = -1;
      for (int p = 0; p < 16; p++) begin
        countPeriod(hc);
        if (p == 0) checkOutput("first_period_high", hc, vecs[i].expFirst);
        total += hc;
        if (hc < mn) mn = hc;
        if (hc > mx) mx = hc;
      end
      checkOutput("total_high", total, vecs[i].expTotal);
      checkOutput("min_period_high", mn, vecs[i].expMin);
      checkOutput("max_period_high", mx, vecs[i].expMax);
    end

    // Mid-period data change must wait for the next load.
    applyStimulus(1'b0, 14'h0000);
    repeat (2) step();
    applyStimulus(1'b1, 14'h0000);
    waitStrobe(n);
    hc = 0;
    for (int c = 0; c < 100; c++) begin step(); hc += int'(pwm_o); end
    applyStimulus(1'b1, 14'h1000);
    for (int c = 0; c < 156; c++) begin step(); hc += int'(pwm_o); end
    checkOutput("period_before_change", hc, 128);
    checkOutput("sample_at_strobe", int'(sample_o), 'h1000);
    countPeriod(hc);
    checkOutput("period_after_change", hc, 192);

    // Asynchronous reset with the output high, then restart from a fresh load.
    applyStimulus(1'b0, 14'h0020);
    repeat (2) step();
    applyStimulus(1'b1, 14'h0020);
    waitStrobe(n);
    repeat (50) step();
    checkOutput("pre_reset_pwm", int'(pwm_o), 1);
    #2 rstn_i = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_pwm", int'(pwm_o), 0);
    checkOutput("async_reset_sample", int'(sample_o), 0);
    checkOutput("async_reset_strobe", int'(period_strobe_o), 0);
    repeat (2) step();
    #2 rstn_i = 1'b1;
    waitStrobe(n);
    checkOutput("strobe_after_release", n, 1);
    countPeriod(hc);
    checkOutput("first_period_after_reset", hc, 129);

    // Enable dropped mid-period, then re-enabled with new data.
    applyStimulus(1'b1, 14'h0000);
    waitStrobe(n);
    repeat (10) step();
    applyStimulus(1'b0, 14'h0000);
    step();
    checkOutput("pwm_after_disable", int'(pwm_o), 0);
    strobes = 0;
    for (int c = 0; c < 300; c++) begin step(); strobes += int'(period_strobe_o); end
    checkOutput("strobes_while_disabled", strobes, 0);
    applyStimulus(1'b0, 14'h1000);
    step();
    applyStimulus(1'b1, 14'h1000);
    waitStrobe(n);
    checkOutput("reenable_strobe_latency", n, 1);
    checkOutput("reenable_sample", int'(sample_o), 'h1000);
    countPeriod(hc);
    checkOutput("reenable_period_high", hc, 192);

    for (int c = 0; c < 6000; c++) begin
      logic en;
      en = enable_i;
      if ($urandom_range(499) == 0) en = ~en;
      applyStimulus(en, 14'($urandom_range(16383)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
